// File: rtl/fetch_if_id_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Owns the PC, applies hazard-unit stalls and branch redirects/flushes, and counts stall/flush events.
module fetch_if_id_stage #(
    parameter int unsigned       size      = 32,
    parameter logic [size-1:0]   RESET_PC  = '0,
    parameter logic [size-1:0]   NOP_INSTR = size'(32'h0000_0013),
    parameter int unsigned       CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PC_write,
    input  logic             IF_ID_reg_write_en,
    input  logic             flush_IF_ID,
    input  logic             redirect_valid,
    input  logic [size-1:0]  redirect_pc,
    input  logic             pred_taken,
    input  logic [size-1:0]  pred_target,
    input  logic [size-1:0]  imem_rdata,
    output logic [size-1:0]  imem_addr,
    output logic [size-1:0]  instruction_ID_out,
    output logic [size-1:0]  pc_ID_out,
    output logic [size-1:0]  pc_plus4_ID_out,
    output logic             pred_taken_ID_out,
    output logic             valid_ID_out,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic [size-1:0]  pc_q, pc_d;
    logic [size-1:0]  instr_q, instr_d;
    logic [size-1:0]  id_pc_q, id_pc_d;
    logic [size-1:0]  id_pc4_q, id_pc4_d;
    logic             id_pred_q, id_pred_d;
    logic             id_valid_q, id_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [size-1:0]  pc_plus4;
    logic             stall_event;
    logic             unused_low_bits;

    // Fetch targets are word aligned, so the low two bits of redirect/predicted targets are dropped.
    assign unused_low_bits = ^{redirect_pc[1:0], pred_target[1:0]};

    assign pc_plus4    = pc_q + size'(4);
    assign stall_event = !PC_write && !redirect_valid;

    always_comb begin
        pc_d = pc_plus4;
        if (redirect_valid) begin
            pc_d = {redirect_pc[size-1:2], 2'b00};
        end else if (!PC_write) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = {pred_target[size-1:2], 2'b00};
        end
    end

    // Flush wins over hold so a squashed instruction never lingers in ID during a stall.
    always_comb begin
        instr_d    = instr_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_pred_d  = id_pred_q;
        id_valid_d = id_valid_q;
        if (flush_IF_ID) begin
            instr_d    = NOP_INSTR;
            id_pc_d    = '0;
            id_pc4_d   = '0;
            id_pred_d  = 1'b0;
            id_valid_d = 1'b0;
        end else if (IF_ID_reg_write_en) begin
            instr_d    = imem_rdata;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_plus4;
            id_pred_d  = pred_taken;
            id_valid_d = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_event && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_IF_ID && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INSTR;
            id_pc_q     <= '0;
            id_pc4_q    <= '0;
            id_pred_q   <= 1'b0;
            id_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            id_pc_q     <= id_pc_d;
            id_pc4_q    <= id_pc4_d;
            id_pred_q   <= id_pred_d;
            id_valid_q  <= id_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign imem_addr          = pc_q;
    assign instruction_ID_out = instr_q;
    assign pc_ID_out          = id_pc_q;
    assign pc_plus4_ID_out    = id_pc4_q;
    assign pred_taken_ID_out  = id_pred_q;
    assign valid_ID_out       = id_valid_q;
    assign stall_count        = stall_cnt_q;
    assign flush_count        = flush_cnt_q;

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Self-checking bench for fetch_if_id_stage: directed scenarios plus randomized traffic against a behavioural model.
// A second instance with 4-bit counters exercises counter saturation in a short run.
module tb_fetch_if_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        PC_write;
    logic        IF_ID_reg_write_en;
    logic        flush_IF_ID;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        pred_taken;
    logic [31:0] pred_target;

    logic [31:0] imem_rdata, imem_addr, instruction_ID_out, pc_ID_out, pc_plus4_ID_out;
    logic        pred_taken_ID_out, valid_ID_out;
    logic [15:0] stall_count, flush_count;

    logic [31:0] imem_rdata_s, imem_addr_s, instruction_ID_out_s, pc_ID_out_s, pc_plus4_ID_out_s;
    logic        pred_taken_ID_out_s, valid_ID_out_s;
    logic [3:0]  stall_count_s, flush_count_s;

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the visible state
    logic [31:0] m_pc, m_instr, m_idpc, m_idpc4;
    logic        m_pred, m_valid;
    int          m_stall, m_flush;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata   = instr_of(imem_addr);
    assign imem_rdata_s = instr_of(imem_addr_s);

    always #5 clk = ~clk;

    fetch_if_id_stage dut (
        .clk(clk), .rst(rst), .PC_write(PC_write), .IF_ID_reg_write_en(IF_ID_reg_write_en),
        .flush_IF_ID(flush_IF_ID), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .imem_rdata(imem_rdata),
        .imem_addr(imem_addr), .instruction_ID_out(instruction_ID_out), .pc_ID_out(pc_ID_out),
        .pc_plus4_ID_out(pc_plus4_ID_out), .pred_taken_ID_out(pred_taken_ID_out),
        .valid_ID_out(valid_ID_out), .stall_count(stall_count), .flush_count(flush_count)
    );

    fetch_if_id_stage #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .PC_write(PC_write), .IF_ID_reg_write_en(IF_ID_reg_write_en),
        .flush_IF_ID(flush_IF_ID), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .imem_rdata(imem_rdata_s),
        .imem_addr(imem_addr_s), .instruction_ID_out(instruction_ID_out_s), .pc_ID_out(pc_ID_out_s),
        .pc_plus4_ID_out(pc_plus4_ID_out_s), .pred_taken_ID_out(pred_taken_ID_out_s),
        .valid_ID_out(valid_ID_out_s), .stall_count(stall_count_s), .flush_count(flush_count_s)
    );

    task automatic set_idle();
        rst = 1'b0; PC_write = 1'b1; IF_ID_reg_write_en = 1'b1; flush_IF_ID = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; pred_taken = 1'b0; pred_target = '0;
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUT and settle.
    task automatic tick();
        logic [31:0] npc;
        if (rst) begin
            npc = 32'h0; m_instr = 32'h13; m_idpc = 0; m_idpc4 = 0; m_pred = 0; m_valid = 0;
            m_stall = 0; m_flush = 0;
        end else begin
            if (redirect_valid)  npc = redirect_pc & ~32'h3;
            else if (!PC_write)  npc = m_pc;
            else if (pred_taken) npc = pred_target & ~32'h3;
            else                 npc = m_pc + 32'd4;
            if (flush_IF_ID) begin
                m_instr = 32'h13; m_idpc = 0; m_idpc4 = 0; m_pred = 0; m_valid = 0;
            end else if (IF_ID_reg_write_en) begin
                m_instr = instr_of(m_pc); m_idpc = m_pc; m_idpc4 = m_pc + 32'd4;
                m_pred = pred_taken; m_valid = 1;
            end
            if (!PC_write && !redirect_valid) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
            if (flush_IF_ID) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
        end
        m_pc = npc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (imem_addr !== 32'h0 || valid_ID_out !== 1'b0 || instruction_ID_out !== 32'h13) begin
            failures++;
            $display("[TB] FAIL reset_state addr=%h valid=%b instr=%h required addr=0 valid=0 instr=00000013",
                     imem_addr, valid_ID_out, instruction_ID_out);
        end
        checks++;
        if (pc_ID_out !== 32'h0 || pc_plus4_ID_out !== 32'h0 || pred_taken_ID_out !== 1'b0 ||
            stall_count !== 16'h0 || flush_count !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_fields pc=%h pc4=%h pred=%b stall=%0d flush=%0d required all zero",
                     pc_ID_out, pc_plus4_ID_out, pred_taken_ID_out, stall_count, flush_count);
        end
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (imem_addr !== 32'(i * 4)) begin
                failures++;
                $display("[TB] FAIL seq_addr%0d got=%h required=%h", i, imem_addr, 32'(i * 4));
            end
            checks++;
            if (instruction_ID_out !== instr_of(32'((i - 1) * 4)) || valid_ID_out !== 1'b1 ||
                pc_ID_out !== 32'((i - 1) * 4)) begin
                failures++;
                $display("[TB] FAIL seq_id%0d instr=%h pc=%h valid=%b required instr=%h pc=%h valid=1",
                         i, instruction_ID_out, pc_ID_out, valid_ID_out,
                         instr_of(32'((i - 1) * 4)), 32'((i - 1) * 4));
            end
        end
    endtask

    task automatic test_stall();
        set_idle();
        tick();
        PC_write = 1'b0;
        IF_ID_reg_write_en = 1'b0;
        tick();
        tick();
        checks++;
        if (imem_addr !== 32'h10 || instruction_ID_out !== instr_of(32'h0C) || stall_count !== 16'd2) begin
            failures++;
            $display("[TB] FAIL stall_hold addr=%h instr=%h stall=%0d required addr=10 instr=%h stall=2",
                     imem_addr, instruction_ID_out, stall_count, instr_of(32'h0C));
        end
        set_idle();
        tick();
        checks++;
        if (imem_addr !== 32'h14 || instruction_ID_out !== instr_of(32'h10)) begin
            failures++;
            $display("[TB] FAIL stall_release addr=%h instr=%h required addr=14 instr=%h",
                     imem_addr, instruction_ID_out, instr_of(32'h10));
        end
    endtask

    task automatic test_predict();
        set_idle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        tick();
        set_idle();
        pred_taken = 1'b1;
        pred_target = 32'h103;
        tick();
        checks++;
        if (imem_addr !== 32'h100 || instruction_ID_out !== instr_of(32'h20) || pred_taken_ID_out !== 1'b1 ||
            pc_ID_out !== 32'h20 || pc_plus4_ID_out !== 32'h24) begin
            failures++;
            $display("[TB] FAIL predict addr=%h instr=%h pred=%b pc=%h pc4=%h required 100 %h 1 20 24",
                     imem_addr, instruction_ID_out, pred_taken_ID_out, pc_ID_out, pc_plus4_ID_out,
                     instr_of(32'h20));
        end
        set_idle();
    endtask

    task automatic test_redirect_flush();
        int stall_before;
        int flush_before;
        stall_before = m_stall;
        flush_before = m_flush;
        set_idle();
        PC_write = 1'b0;
        IF_ID_reg_write_en = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        flush_IF_ID = 1'b1;
        tick();
        checks++;
        if (imem_addr !== 32'h200 || instruction_ID_out !== 32'h13 || valid_ID_out !== 1'b0 || pc_ID_out !== 32'h0) begin
            failures++;
            $display("[TB] FAIL redirect_flush addr=%h instr=%h valid=%b pc=%h required 200 00000013 0 0",
                     imem_addr, instruction_ID_out, valid_ID_out, pc_ID_out);
        end
        checks++;
        if (32'(flush_count) !== 32'(flush_before + 1) || 32'(stall_count) !== 32'(stall_before)) begin
            failures++;
            $display("[TB] FAIL redirect_counts flush=%0d stall=%0d required flush=%0d stall=%0d",
                     flush_count, stall_count, flush_before + 1, stall_before);
        end
        set_idle();
        tick();
        checks++;
        if (instruction_ID_out !== instr_of(32'h200) || valid_ID_out !== 1'b1 || imem_addr !== 32'h204) begin
            failures++;
            $display("[TB] FAIL redirect_id instr=%h valid=%b addr=%h required %h 1 204",
                     instruction_ID_out, valid_ID_out, imem_addr, instr_of(32'h200));
        end
    endtask

    task automatic test_wrap();
        set_idle();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("[TB] FAIL wrap_redirect addr=%h required fffffffc", imem_addr);
        end
        set_idle();
        tick();
        checks++;
        if (imem_addr !== 32'h0 || pc_plus4_ID_out !== 32'h0 || pc_ID_out !== 32'hFFFF_FFFC) begin
            failures++;
            $display("[TB] FAIL wrap addr=%h pc4=%h pc=%h required 0 0 fffffffc",
                     imem_addr, pc_plus4_ID_out, pc_ID_out);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            rst                = ($urandom_range(0, 39) == 0);
            PC_write           = ($urandom_range(0, 3) != 0);
            IF_ID_reg_write_en = ($urandom_range(0, 3) != 0);
            flush_IF_ID        = ($urandom_range(0, 7) == 0);
            redirect_valid     = ($urandom_range(0, 7) == 0);
            redirect_pc        = $urandom;
            pred_taken         = ($urandom_range(0, 3) == 0);
            pred_target        = $urandom;
            tick();
            checks++;
            if (imem_addr !== m_pc) begin
                failures++;
                $display("[TB] FAIL rand_addr cyc=%0d got=%h required=%h", n, imem_addr, m_pc);
            end
            checks++;
            if (instruction_ID_out !== m_instr || pc_ID_out !== m_idpc || pc_plus4_ID_out !== m_idpc4) begin
                failures++;
                $display("[TB] FAIL rand_id cyc=%0d got=%h/%h/%h required=%h/%h/%h", n,
                         instruction_ID_out, pc_ID_out, pc_plus4_ID_out, m_instr, m_idpc, m_idpc4);
            end
            checks++;
            if (pred_taken_ID_out !== m_pred || valid_ID_out !== m_valid) begin
                failures++;
                $display("[TB] FAIL rand_flags cyc=%0d pred=%b valid=%b required pred=%b valid=%b",
                         n, pred_taken_ID_out, valid_ID_out, m_pred, m_valid);
            end
            checks++;
            if (32'(stall_count) !== 32'(m_stall) || 32'(flush_count) !== 32'(m_flush)) begin
                failures++;
                $display("[TB] FAIL rand_counts cyc=%0d stall=%0d flush=%0d required stall=%0d flush=%0d",
                         n, stall_count, flush_count, m_stall, m_flush);
            end
        end
        set_idle();
    endtask

    task automatic test_saturation();
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        PC_write = 1'b0;
        for (int i = 0; i < 21; i++) tick();
        checks++;
        if (stall_count_s !== 4'hF || stall_count !== 16'd21) begin
            failures++;
            $display("[TB] FAIL stall_saturate small=%h wide=%0d required small=f wide=21",
                     stall_count_s, stall_count);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (stall_count_s !== 4'h0 || stall_count !== 16'h0 || imem_addr !== 32'h0 || valid_ID_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_stall small=%h wide=%0d addr=%h valid=%b required 0 0 0 0",
                     stall_count_s, stall_count, imem_addr, valid_ID_out);
        end
        set_idle();
        tick();
        checks++;
        if (imem_addr !== 32'h4 || instruction_ID_out !== instr_of(32'h0) || valid_ID_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL post_reset_fetch addr=%h instr=%h valid=%b required 4 %h 1",
                     imem_addr, instruction_ID_out, valid_ID_out, instr_of(32'h0));
        end
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        test_reset();
        test_stall();
        test_predict();
        test_redirect_flush();
        test_wrap();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
